// File: rtl/strela_imn_strided_if.sv
// rtl/strela_imn_strided_if.sv - OBI read channel between the strided reader and memory
interface strela_imn_strided_if;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/strela_imn_strided.sv
// rtl/strela_imn_strided.sv - strided OBI reader feeding a FWFT FIFO and a valid/ready word stream
module strela_imn_strided #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned REP_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 start_i,
    input  logic [31:0]          addr_i,
    input  logic [15:0]          size_i,
    input  logic [15:0]          stride_i,
    input  logic [REP_W-1:0]     reps_i,
    strela_imn_strided_if.master masters,
    output logic [31:0]          dout_o,
    output logic                 dout_v_o,
    input  logic                 dout_r_i,
    output logic                 done_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    typedef enum logic [2:0] {IDLE, RUN, WAIT, DONE, FLUSH} state_t;

    state_t           state;
    logic [31:0]      base_q;
    logic [15:0]      size_q;
    logic [15:0]      stride_q;
    logic [REP_W-1:0] reps_q;
    logic [15:0]      word_cnt;
    logic [REP_W-1:0] pass_cnt;
    logic [31:0]      cur_addr;
    logic             req_q;
    logic             done_q;

    logic [CW-1:0]    fifo_count;
    logic [CW-1:0]    outstanding;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [31:0]      mem [DEPTH];

    logic             issued;
    logic             push;
    logic             pop;
    logic [CW-1:0]    next_out;
    logic [CW-1:0]    next_cnt;
    logic [CW:0]      occupancy;
    logic             room;
    logic             last_word;
    logic             last_pass;

    assign issued    = req_q & masters.gnt;
    assign push      = masters.rvalid & (state != FLUSH);
    assign pop       = dout_v_o & dout_r_i;
    assign next_out  = outstanding + CW'(issued) - CW'(masters.rvalid);
    assign next_cnt  = fifo_count + CW'(push) - CW'(pop);
    // Every granted request reserves a FIFO slot, so responses can never overflow.
    assign occupancy = {1'b0, next_cnt} + {1'b0, next_out};
    assign room      = occupancy < DEPTH_W;
    assign last_word = (word_cnt == size_q - 16'd1);
    assign last_pass = (pass_cnt == reps_q - REP_W'(1));

    assign masters.req   = req_q;
    assign masters.addr  = cur_addr;
    assign masters.we    = 1'b0;
    assign masters.be    = 4'hF;
    assign masters.wdata = 32'h0;

    assign dout_v_o = (fifo_count != '0);
    assign dout_o   = mem[rptr];
    assign done_o   = done_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr] <= masters.rdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= IDLE;
            base_q      <= '0;
            size_q      <= '0;
            stride_q    <= '0;
            reps_q      <= '0;
            word_cnt    <= '0;
            pass_cnt    <= '0;
            cur_addr    <= '0;
            req_q       <= 1'b0;
            done_q      <= 1'b0;
            fifo_count  <= '0;
            outstanding <= '0;
            wptr        <= '0;
            rptr        <= '0;
        end else begin
            outstanding <= next_out;
            if (clr_i) begin
                fifo_count <= '0;
                wptr       <= '0;
                rptr       <= '0;
            end else begin
                fifo_count <= next_cnt;
                if (push) wptr <= wptr + AW'(1);
                if (pop)  rptr <= rptr + AW'(1);
            end

            if (clr_i) begin
                req_q  <= 1'b0;
                done_q <= 1'b0;
                state  <= (next_out != '0) ? FLUSH : IDLE;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start_i) begin
                            base_q   <= addr_i;
                            size_q   <= size_i;
                            stride_q <= stride_i;
                            reps_q   <= (reps_i == '0) ? REP_W'(1) : reps_i;
                            word_cnt <= '0;
                            pass_cnt <= '0;
                            cur_addr <= addr_i;
                            req_q    <= (size_i != 16'd0);
                            done_q   <= (size_i == 16'd0);
                            state    <= (size_i == 16'd0) ? DONE : RUN;
                        end
                    end
                    RUN: begin
                        if (issued) begin
                            if (last_word) begin
                                word_cnt <= '0;
                                cur_addr <= base_q;
                                if (last_pass) begin
                                    req_q <= 1'b0;
                                    state <= WAIT;
                                end else begin
                                    pass_cnt <= pass_cnt + REP_W'(1);
                                    req_q    <= room;
                                end
                            end else begin
                                word_cnt <= word_cnt + 16'd1;
                                cur_addr <= cur_addr + {16'h0, stride_q};
                                req_q    <= room;
                            end
                        end else if (!req_q) begin
                            req_q <= room;
                        end
                    end
                    WAIT: begin
                        if (outstanding == '0 && fifo_count == '0) begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                    FLUSH: begin
                        if (next_out == '0) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_strela_imn_strided.sv
// tb/tb_strela_imn_strided.sv - directed bench with OBI memory model and address/data scoreboards
module tb_strela_imn_strided;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        start;
    logic [31:0] addr;
    logic [15:0] size;
    logic [15:0] stride;
    logic [7:0]  reps;
    logic [31:0] dout;
    logic        dout_v;
    logic        dout_r;
    logic        done;

    always #5 clk = ~clk;

    strela_imn_strided_if bus ();

    strela_imn_strided #(.DEPTH(4), .REP_W(8)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .clr_i    (clr),
        .start_i  (start),
        .addr_i   (addr),
        .size_i   (size),
        .stride_i (stride),
        .reps_i   (reps),
        .masters  (bus),
        .dout_o   (dout),
        .dout_v_o (dout_v),
        .dout_r_i (dout_r),
        .done_o   (done)
    );

    int total = 0;
    int bad = 0;
    int grant_cnt = 0;
    int beat_cnt = 0;
    int gnt_limit = 1000000;
    bit gnt_en = 1'b1;
    bit hold_resp = 1'b0;
    logic        prev_grant = 1'b0;
    logic [31:0] prev_gaddr = 32'h0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] pend[$];

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'd3) ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory slave and stream consumer run on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        logic [31:0] a;
        logic [31:0] e;
        if (!rst_n) begin
            bus.gnt    = 1'b0;
            bus.rvalid = 1'b0;
            bus.rdata  = 32'h0;
            prev_grant = 1'b0;
            pend.delete();
        end else begin
            if (prev_grant) begin
                grant_cnt++;
                e = (exp_addr.size() > 0) ? exp_addr.pop_front() : 32'hDEAD_BEEF;
                check("grant_addr", prev_gaddr, e);
                check("grant_attr", {bus.we, bus.be, bus.wdata[3:0]}, {1'b0, 4'hF, 4'h0});
                pend.push_back(prev_gaddr);
            end
            if (!hold_resp && pend.size() > 0) begin
                a = pend.pop_front();
                bus.rvalid = 1'b1;
                bus.rdata  = mem_f(a);
            end else begin
                bus.rvalid = 1'b0;
                bus.rdata  = 32'h0;
            end
            bus.gnt    = bus.req && gnt_en && (grant_cnt < gnt_limit);
            prev_grant = bus.gnt;
            prev_gaddr = bus.addr;
            if (dout_v && dout_r) begin
                beat_cnt++;
                e = (exp_data.size() > 0) ? exp_data.pop_front() : 32'hDEAD_BEEF;
                check("beat_data", dout, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [15:0] s, input logic [15:0] st,
                        input logic [7:0] r, input bit expect_data);
        int passes;
        logic [31:0] x;
        passes = (r == 8'd0) ? 1 : int'(r);
        for (int p = 0; p < passes; p++) begin
            for (int n = 0; n < int'(s); n++) begin
                x = a + 32'(n) * {16'h0, st};
                exp_addr.push_back(x);
                if (expect_data) exp_data.push_back(mem_f(x));
            end
        end
        addr = a; size = s; stride = st; reps = r;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && !done; i++) step();
        check(tag, {31'h0, done}, 32'h1);
    endtask

    task automatic check_drained(input string tag, input int beats);
        check({tag, "_addrq"}, exp_addr.size(), 32'h0);
        check({tag, "_dataq"}, exp_data.size(), 32'h0);
        check({tag, "_beats"}, beat_cnt, beats);
    endtask

    initial begin
        int g0;
        rst_n = 1'b0; clr = 1'b0; start = 1'b0; dout_r = 1'b1;
        addr = 32'h0; size = 16'h0; stride = 16'h0; reps = 8'h0;
        step(); step();
        check("rst_req", {31'h0, bus.req}, 32'h0);
        check("rst_addr", bus.addr, 32'h0);
        check("rst_dout_v", {31'h0, dout_v}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        rst_n = 1'b1;
        step();

        // Basic contiguous pass
        beat_cnt = 0;
        load(32'h1000, 16'd4, 16'd4, 8'd1, 1'b1);
        pulse_start();
        check("t1_req_first", {31'h0, bus.req}, 32'h1);
        check("t1_done_low", {31'h0, done}, 32'h0);
        wait_done("t1_done", 200);
        check_drained("t1", 4);

        // Two passes with stride 8
        beat_cnt = 0;
        load(32'h1000, 16'd3, 16'd8, 8'd2, 1'b1);
        pulse_start();
        wait_done("t2_done", 200);
        check_drained("t2", 6);

        // Back-pressure: FIFO depth bounds outstanding grants
        beat_cnt = 0;
        dout_r = 1'b0;
        g0 = grant_cnt;
        load(32'h2000, 16'd10, 16'd4, 8'd1, 1'b1);
        pulse_start();
        repeat (20) step();
        check("t3_grants", grant_cnt - g0, 32'd4);
        check("t3_req_low", {31'h0, bus.req}, 32'h0);
        check("t3_dout_v", {31'h0, dout_v}, 32'h1);
        dout_r = 1'b1;
        wait_done("t3_done", 300);
        check_drained("t3", 10);

        // Grant withheld on the first request
        beat_cnt = 0;
        gnt_en = 1'b0;
        load(32'h3000, 16'd3, 16'd4, 8'd1, 1'b1);
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            check("t4_req_hold", {31'h0, bus.req}, 32'h1);
            check("t4_addr_hold", bus.addr, 32'h3000);
            step();
        end
        gnt_en = 1'b1;
        wait_done("t4_done", 200);
        check_drained("t4", 3);

        // Clear with two responses outstanding
        beat_cnt = 0;
        hold_resp = 1'b1;
        gnt_limit = grant_cnt + 2;
        load(32'h4000, 16'd2, 16'd4, 8'd1, 1'b0);
        size = 16'd8;
        pulse_start();
        repeat (6) step();
        check("t5_no_data", {31'h0, dout_v}, 32'h0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("t5_clr_req", {31'h0, bus.req}, 32'h0);
        check("t5_clr_done", {31'h0, done}, 32'h0);
        hold_resp = 1'b0;
        gnt_limit = 1000000;
        for (int i = 0; i < 5; i++) begin
            check("t5_flush_dout_v", {31'h0, dout_v}, 32'h0);
            step();
        end
        check("t5_pend_empty", pend.size(), 32'h0);
        load(32'h5000, 16'd3, 16'd4, 8'd1, 1'b1);
        pulse_start();
        wait_done("t5_restart_done", 200);
        check_drained("t5", 3);

        // Zero-size transfer completes at once
        beat_cnt = 0;
        load(32'h6000, 16'd0, 16'd4, 8'd1, 1'b1);
        pulse_start();
        check("t6_done_now", {31'h0, done}, 32'h1);
        check("t6_no_req", {31'h0, bus.req}, 32'h0);

        // Address wrap past 2^32
        load(32'hFFFF_FFFC, 16'd2, 16'd4, 8'd1, 1'b1);
        pulse_start();
        check("t7_done_cleared", {31'h0, done}, 32'h0);
        wait_done("t7_done", 200);
        check_drained("t7", 2);

        // Zero repeats behave as one pass
        beat_cnt = 0;
        load(32'h7000, 16'd2, 16'd12, 8'd0, 1'b1);
        pulse_start();
        wait_done("t8_done", 200);
        check_drained("t8", 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
